// File: rtl/zombie_sprite_unit.sv
// One zombie slot: frame-rate life-cycle sequencer plus a two-stage pixel path
// that presents a sprite ROM address and a matching zom_on flag to the mapper.
module zombie_sprite_unit #(
  parameter int SPR_W        = 64,
  parameter int SPR_H        = 96,
  parameter int X_START      = 640,
  parameter int HOUSE_X      = 40,
  parameter int ROW_Y0       = 80,
  parameter int ROW_H        = 96,
  parameter int HP_MAX       = 10,
  parameter int SPEED_DIV    = 2,
  parameter int ANIM_DIV     = 8,
  parameter int DYING_FRAMES = 30
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        spawn,
  input  logic [2:0]  spawn_row,
  input  logic        hit,
  input  logic        blocked,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [15:0] zom_addr,
  output logic        zom_on,
  output logic [9:0]  zom_x,
  output logic [9:0]  zom_y,
  output logic [2:0]  zom_state,
  output logic        alive,
  output logic        house_reached
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WALK  = 3'd1,
    ST_EAT   = 3'd2,
    ST_DYING = 3'd3
  } state_t;

  state_t      r_state, w_stateNext;
  logic [9:0]  r_x, r_y, w_xNext, w_yNext;
  logic [3:0]  r_hp, w_hpNext, w_hpDec;
  logic [7:0]  r_step, w_stepNext;
  logic [7:0]  r_animDiv, w_animDivNext;
  logic [7:0]  r_dying, w_dyingNext;
  logic [1:0]  r_anim, w_animNext;
  logic        r_house, w_houseNext;
  logic [2:0]  w_rowClamp;
  logic [2:0]  w_frame;
  logic [10:0] w_dx, w_dy, w_xl, w_xr, w_yt, w_yb;
  logic        w_inside;
  logic [15:0] w_addr;
  logic [15:0] r_addr;
  logic        r_inside, r_zomOn;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_x       <= 10'(X_START);
      r_y       <= 10'(ROW_Y0);
      r_hp      <= '0;
      r_step    <= '0;
      r_animDiv <= '0;
      r_anim    <= '0;
      r_dying   <= '0;
      r_house   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_x       <= w_xNext;
      r_y       <= w_yNext;
      r_hp      <= w_hpNext;
      r_step    <= w_stepNext;
      r_animDiv <= w_animDivNext;
      r_anim    <= w_animNext;
      r_dying   <= w_dyingNext;
      r_house   <= w_houseNext;
    end
  end

  // A killing hit outranks the frame-rate EAT/WALK decision in the same cycle.
  always_comb begin
    w_stateNext   = r_state;
    w_xNext       = r_x;
    w_yNext       = r_y;
    w_hpNext      = r_hp;
    w_stepNext    = r_step;
    w_animDivNext = r_animDiv;
    w_animNext    = r_anim;
    w_dyingNext   = r_dying;
    w_houseNext   = r_house;
    w_rowClamp    = (spawn_row > 3'd4) ? 3'd4 : spawn_row;
    w_hpDec       = (hit && (r_hp != 4'd0)) ? (r_hp - 4'd1) : r_hp;

    case (r_state)
      ST_IDLE: begin
        if (spawn) begin
          w_stateNext   = ST_WALK;
          w_xNext       = 10'(X_START);
          w_yNext       = 10'(ROW_Y0) + 10'(w_rowClamp) * 10'(ROW_H);
          w_hpNext      = 4'(HP_MAX);
          w_animNext    = '0;
          w_animDivNext = '0;
          w_stepNext    = '0;
        end
      end
      ST_WALK, ST_EAT: begin
        w_hpNext = w_hpDec;
        if (w_hpDec == 4'd0) begin
          w_stateNext = ST_DYING;
          w_dyingNext = '0;
        end else if (frame_start) begin
          if (r_state == ST_EAT) begin
            if (!blocked) w_stateNext = ST_WALK;
          end else if (blocked) begin
            w_stateNext = ST_EAT;
          end else begin
            if (r_step == 8'(SPEED_DIV - 1)) begin
              w_stepNext = '0;
              if ({1'b0, r_x} <= 11'(HOUSE_X + 1)) begin
                w_xNext     = 10'(HOUSE_X);
                w_houseNext = 1'b1;
              end else begin
                w_xNext = r_x - 10'd1;
              end
            end else begin
              w_stepNext = r_step + 8'd1;
            end
            if (r_animDiv == 8'(ANIM_DIV - 1)) begin
              w_animDivNext = '0;
              w_animNext    = r_anim + 2'd1;
            end else begin
              w_animDivNext = r_animDiv + 8'd1;
            end
          end
        end
      end
      ST_DYING: begin
        if (frame_start) begin
          if (r_dying == 8'(DYING_FRAMES - 1)) begin
            w_stateNext = ST_IDLE;
            w_dyingNext = '0;
          end else begin
            w_dyingNext = r_dying + 8'd1;
          end
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Bounds are widened to 11 bits so a sprite hanging off the right or bottom
  // edge does not wrap around to the opposite side of the screen.
  always_comb begin
    w_frame = (r_state == ST_EAT)   ? 3'd4 :
              (r_state == ST_DYING) ? 3'd5 : {1'b0, r_anim};
    w_dx    = {1'b0, DrawX};
    w_dy    = {1'b0, DrawY};
    w_xl    = {1'b0, r_x};
    w_yt    = {1'b0, r_y};
    w_xr    = w_xl + 11'(SPR_W - 1);
    w_yb    = w_yt + 11'(SPR_H - 1);
    w_inside = (r_state != ST_IDLE) && (w_dx >= w_xl) && (w_dx <= w_xr)
               && (w_dy >= w_yt) && (w_dy <= w_yb);
    w_addr  = 16'(w_frame) * 16'(SPR_W * SPR_H)
              + (16'(DrawY) - 16'(r_y)) * 16'(SPR_W)
              + (16'(DrawX) - 16'(r_x));
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_addr   <= '0;
      r_inside <= 1'b0;
      r_zomOn  <= 1'b0;
    end else begin
      r_addr   <= w_inside ? w_addr : 16'd0;
      r_inside <= w_inside;
      r_zomOn  <= r_inside;
    end
  end

  assign zom_addr      = r_addr;
  assign zom_on        = r_zomOn;
  assign zom_x         = r_x;
  assign zom_y         = r_y;
  assign zom_state     = r_state;
  assign alive         = (r_state == ST_WALK) || (r_state == ST_EAT);
  assign house_reached = r_house;

endmodule

// File: tb/tb_zombie_sprite_unit.sv
// Directed bench for zombie_sprite_unit: life cycle, animation, house limit
// and the two-cycle pixel path, with hand-computed expected values.
module tb_zombie_sprite_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        spawn = 1'b0;
  logic [2:0]  spawn_row = 3'd0;
  logic        hit = 1'b0;
  logic        blocked = 1'b0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic [15:0] zom_addr;
  logic        zom_on;
  logic [9:0]  zom_x;
  logic [9:0]  zom_y;
  logic [2:0]  zom_state;
  logic        alive;
  logic        house_reached;

  int checks = 0;
  int failures = 0;
  int rows [5] = '{79, 80, 127, 175, 176};
  logic expPrev;

  zombie_sprite_unit dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .spawn        (spawn),
    .spawn_row    (spawn_row),
    .hit          (hit),
    .blocked      (blocked),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .zom_addr     (zom_addr),
    .zom_on       (zom_on),
    .zom_x        (zom_x),
    .zom_y        (zom_y),
    .zom_state    (zom_state),
    .alive        (alive),
    .house_reached(house_reached)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One-cycle pulses on frame_start/spawn/hit; blocked is a level and is left as set.
  task automatic applyStimulus(input logic fs, input logic sp, input logic ht,
                               input logic bl);
    frame_start = fs;
    spawn       = sp;
    hit         = ht;
    blocked     = bl;
    tick();
    frame_start = 1'b0;
    spawn       = 1'b0;
    hit         = 1'b0;
  endtask

  task automatic frames(input int n, input logic bl);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, bl);
  endtask

  task automatic pulseReset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic presentPixel(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
  endtask

  initial begin
    tick();
    tick();
    Reset = 1'b0;
    tick();
    checkOutput("rst_state", zom_state, 0);
    checkOutput("rst_alive", alive, 0);
    checkOutput("rst_house", house_reached, 0);
    checkOutput("rst_on", zom_on, 0);
    checkOutput("rst_addr", zom_addr, 0);
    checkOutput("rst_x", zom_x, 640);
    checkOutput("rst_y", zom_y, 80);

    spawn_row = 3'd2;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("spawn_state", zom_state, 1);
    checkOutput("spawn_x", zom_x, 640);
    checkOutput("spawn_y", zom_y, 272);
    checkOutput("spawn_alive", alive, 1);
    spawn_row = 3'd4;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("respawn_x", zom_x, 640);
    checkOutput("respawn_y", zom_y, 272);

    frames(20, 1'b0);
    checkOutput("walk20_x", zom_x, 630);
    presentPixel(630, 272);
    checkOutput("walk_addr", zom_addr, 12288);
    checkOutput("walk_on_lat1", zom_on, 0);
    presentPixel(631, 273);
    checkOutput("walk_on_lat2", zom_on, 1);
    checkOutput("walk_addr_off", zom_addr, 12353);
    presentPixel(0, 0);
    tick();

    frames(5, 1'b1);
    checkOutput("eat_state", zom_state, 2);
    checkOutput("eat_x", zom_x, 630);
    checkOutput("eat_alive", alive, 1);
    presentPixel(630, 272);
    checkOutput("eat_addr", zom_addr, 24576);
    presentPixel(0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("unblock_state", zom_state, 1);
    checkOutput("unblock_x", zom_x, 630);
    frames(2, 1'b0);
    checkOutput("resume_x", zom_x, 629);

    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("hit9_state", zom_state, 1);
    checkOutput("hit9_alive", alive, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("kill_state", zom_state, 3);
    checkOutput("kill_alive", alive, 0);
    checkOutput("kill_x", zom_x, 629);
    presentPixel(629, 272);
    checkOutput("dying_addr", zom_addr, 30720);
    presentPixel(0, 0);
    frames(29, 1'b1);
    checkOutput("dying29_state", zom_state, 3);
    frames(1, 1'b0);
    checkOutput("dying30_state", zom_state, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_hit_state", zom_state, 0);
    presentPixel(629, 272);
    tick();
    checkOutput("idle_on", zom_on, 0);
    checkOutput("idle_addr", zom_addr, 0);
    presentPixel(0, 0);

    pulseReset();
    spawn_row = 3'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    frames(1198, 1'b0);
    checkOutput("pre_house_x", zom_x, 41);
    checkOutput("pre_house_flag", house_reached, 0);
    frames(2, 1'b0);
    checkOutput("house_x", zom_x, 40);
    checkOutput("house_flag", house_reached, 1);
    frames(10, 1'b0);
    checkOutput("house_hold_x", zom_x, 40);
    checkOutput("house_hold_flag", house_reached, 1);
    checkOutput("house_hold_state", zom_state, 1);
    pulseReset();
    checkOutput("house_rst_flag", house_reached, 0);
    checkOutput("house_rst_x", zom_x, 640);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    frames(80, 1'b0);
    checkOutput("raster_x", zom_x, 600);
    checkOutput("raster_y", zom_y, 80);
    expPrev = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int x = 595; x <= 639; x++) begin
        presentPixel(x, rows[r]);
        checkOutput("raster_on", zom_on, expPrev);
        expPrev = (x >= 600) && (rows[r] >= 80) && (rows[r] <= 175);
      end
    end
    presentPixel(610, 100);
    tick();
    checkOutput("midline_on", zom_on, 1);
    Reset = 1'b1;
    tick();
    checkOutput("midline_rst_on", zom_on, 0);
    checkOutput("midline_rst_state", zom_state, 0);
    Reset = 1'b0;
    presentPixel(0, 0);

    spawn_row = 3'd7;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("clamp_y", zom_y, 464);
    frames(80, 1'b0);
    presentPixel(610, 470);
    checkOutput("bottom_addr", zom_addr, 12682);
    presentPixel(610, 479);
    checkOutput("bottom_on", zom_on, 1);
    tick();
    checkOutput("bottom_edge_on", zom_on, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
